ysyx_mem_arbiter: RTL and testbench

- Shares the core's single AXI4 master port between three requesters: the IFU read port, the LSU read port and the LSU write port.
- Single-beat transactions only, with one transaction outstanding at a time.
- Priority is fixed (LSU over IFU), plus a starvation guard that forces an IFU grant.
- Handles 32-bit requester data onto the 64-bit AXI data bus (lane steering), maps strobes to AXI size, and checks response ID and status.

---
 rtl/ysyx_arb_pkg.sv | 44 ++++
 rtl/ysyx_mem_arbiter_if.sv | 94 +++++++++
 rtl/ysyx_axi_lane.sv | 27 ++
 rtl/ysyx_mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_arb_pkg.sv
// ------------------------------------------------------------------
// ysyx_arb_pkg : shared types and constants for the memory arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package ysyx_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_AR  = 3'd1,
    S_RD_R   = 3'd2,
    S_WR_AWW = 3'd3,
    S_WR_B   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_IFU   = 2'd1,
    REQ_LSU_R = 2'd2,
    REQ_LSU_W = 2'd3
  } req_t;

  localparam logic [3:0] c_ID_IFU   = 4'd0;
  localparam logic [3:0] c_ID_LSU_R = 4'd1;
  localparam logic [3:0] c_ID_LSU_W = 4'd2;

  localparam logic [1:0] c_BURST_INCR = 2'b01;
  localparam logic [1:0] c_RESP_OKAY  = 2'b00;
  localparam logic [7:0] c_LEN_SINGLE = 8'd0;

  // Byte, half and word masks map directly; anything irregular goes out as a word.
  function automatic logic [2:0] strb2size(input logic [3:0] strb);
    case (strb)
      4'b0001: strb2size = 3'd0;
      4'b0011: strb2size = 3'd1;
      default: strb2size = 3'd2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_mem_arbiter_if.sv
// ------------------------------------------------------------------
// ysyx_req_if / ysyx_axi_if : requester-side and AXI-side bundles
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface ysyx_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ifu_araddr;
  logic              ifu_arvalid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic              ifu_err;
  logic [ADDR_W-1:0] lsu_araddr;
  logic              lsu_arvalid;
  logic [7:0]        lsu_rstrb;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rvalid;
  logic [ADDR_W-1:0] lsu_awaddr;
  logic              lsu_awvalid;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wstrb;
  logic              lsu_wvalid;
  logic              lsu_wready;
  logic              lsu_err;

  modport master (
    output ifu_araddr, ifu_arvalid, lsu_araddr, lsu_arvalid, lsu_rstrb,
           lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    input  ifu_rdata, ifu_rvalid, ifu_err, lsu_rdata, lsu_rvalid,
           lsu_wready, lsu_err
  );

  modport slave (
    input  ifu_araddr, ifu_arvalid, lsu_araddr, lsu_arvalid, lsu_rstrb,
           lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    output ifu_rdata, ifu_rvalid, ifu_err, lsu_rdata, lsu_rvalid,
           lsu_wready, lsu_err
  );
endinterface

interface ysyx_axi_if #(
  parameter int ADDR_W = 32
);
  logic              m_arvalid;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arsize;
  logic [7:0]        m_arlen;
  logic [1:0]        m_arburst;
  logic [3:0]        m_arid;
  logic              m_arready;
  logic              m_rvalid;
  logic [63:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic [3:0]        m_rid;
  logic              m_rready;
  logic              m_awvalid;
  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awsize;
  logic [7:0]        m_awlen;
  logic [1:0]        m_awburst;
  logic [3:0]        m_awid;
  logic              m_awready;
  logic              m_wvalid;
  logic [63:0]       m_wdata;
  logic [7:0]        m_wstrb;
  logic              m_wlast;
  logic              m_wready;
  logic              m_bvalid;
  logic [1:0]        m_bresp;
  logic [3:0]        m_bid;
  logic              m_bready;

  modport master (
    output m_arvalid, m_araddr, m_arsize, m_arlen, m_arburst, m_arid, m_rready,
           m_awvalid, m_awaddr, m_awsize, m_awlen, m_awburst, m_awid,
           m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
           m_awready, m_wready, m_bvalid, m_bresp, m_bid
  );

  modport slave (
    input  m_arvalid, m_araddr, m_arsize, m_arlen, m_arburst, m_arid, m_rready,
           m_awvalid, m_awaddr, m_awsize, m_awlen, m_awburst, m_awid,
           m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
           m_awready, m_wready, m_bvalid, m_bresp, m_bid
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_axi_lane.sv
// ------------------------------------------------------------------
// ysyx_axi_lane : 32-bit requester data onto the 64-bit AXI data lanes
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ysyx_axi_lane #(
  parameter int DATA_W = 32
) (
  input  wire logic                  i_hi,
  input  wire logic [2*DATA_W-1:0]   i_rdata,
  output logic      [DATA_W-1:0]     o_rdata,
  input  wire logic [DATA_W-1:0]     i_wdata,
  input  wire logic [DATA_W/8-1:0]   i_wstrb,
  output logic      [2*DATA_W-1:0]   o_wdata,
  output logic      [DATA_W/4-1:0]   o_wstrb
);

  localparam int c_NB = DATA_W / 8;

  assign o_rdata = i_hi ? i_rdata[2*DATA_W-1:DATA_W] : i_rdata[DATA_W-1:0];
  assign o_wdata = {i_wdata, i_wdata};
  assign o_wstrb = i_hi ? {i_wstrb, {c_NB{1'b0}}} : {{c_NB{1'b0}}, i_wstrb};

endmodule

`default_nettype wire

// File: rtl/ysyx_mem_arbiter.sv
// ------------------------------------------------------------------
// ysyx_mem_arbiter : single-beat AXI4 arbiter, LSU over IFU with starvation guard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ysyx_mem_arbiter
  import ysyx_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
  ysyx_req_if.slave  req,
  ysyx_axi_if.master axi
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  state_t              r_state;
  req_t                r_req;
  logic [3:0]          r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_size;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [3:0]          r_starve_cnt;
  logic                r_aw_done, r_w_done;
  logic                r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic                r_ifu_rvalid, r_lsu_rvalid, r_lsu_wready;
  logic                r_ifu_err, r_lsu_err;
  logic [DATA_W-1:0]   r_ifu_rdata, r_lsu_rdata;

  req_t                w_grant;
  logic [3:0]          w_gid;
  logic [ADDR_W-1:0]   w_gaddr;
  logic [2:0]          w_gsize;
  logic                w_store, w_force_ifu, w_rerr, w_berr, w_aw_fin, w_w_fin;
  logic [DATA_W-1:0]   w_rd_data;
  logic [63:0]         w_wdata64;
  logic [7:0]          w_wstrb8;
  logic [DATA_W-1:0]   w_unused_rdata;
  logic [63:0]         w_unused_wdata;
  logic [7:0]          w_unused_wstrb;
  logic                w_unused;

  assign w_store     = req.lsu_awvalid & req.lsu_wvalid;
  assign w_force_ifu = (r_starve_cnt == c_STARVE_MAX) & req.ifu_arvalid;
  assign w_rerr      = (axi.m_rresp != c_RESP_OKAY) | (axi.m_rid != r_id);
  assign w_berr      = (axi.m_bresp != c_RESP_OKAY) | (axi.m_bid != r_id);
  assign w_aw_fin    = r_aw_done | (r_awvalid & axi.m_awready);
  assign w_w_fin     = r_w_done  | (r_wvalid  & axi.m_wready);
  assign w_unused    = ^{axi.m_rlast, req.lsu_rstrb[7:4], req.lsu_wstrb[7:4],
                         w_unused_rdata, w_unused_wdata, w_unused_wstrb};

  always_comb begin
    w_grant = REQ_NONE;
    w_gid   = c_ID_IFU;
    w_gaddr = req.ifu_araddr;
    w_gsize = 3'd2;
    if (w_force_ifu) begin
      w_grant = REQ_IFU;
    end else if (w_store) begin
      w_grant = REQ_LSU_W;
      w_gid   = c_ID_LSU_W;
      w_gaddr = req.lsu_awaddr;
      w_gsize = strb2size(req.lsu_wstrb[3:0]);
    end else if (req.lsu_arvalid) begin
      w_grant = REQ_LSU_R;
      w_gid   = c_ID_LSU_R;
      w_gaddr = req.lsu_araddr;
      w_gsize = strb2size(req.lsu_rstrb[3:0]);
    end else if (req.ifu_arvalid) begin
      w_grant = REQ_IFU;
    end
  end

  ysyx_axi_lane #(.DATA_W(DATA_W)) u_rd_lane (
    .i_hi    (r_addr[2]),
    .i_rdata (axi.m_rdata),
    .o_rdata (w_rd_data),
    .i_wdata ('0),
    .i_wstrb ('0),
    .o_wdata (w_unused_wdata),
    .o_wstrb (w_unused_wstrb)
  );

  ysyx_axi_lane #(.DATA_W(DATA_W)) u_wr_lane (
    .i_hi    (r_addr[2]),
    .i_rdata ('0),
    .o_rdata (w_unused_rdata),
    .i_wdata (r_wdata),
    .i_wstrb (r_wstrb),
    .o_wdata (w_wdata64),
    .o_wstrb (w_wstrb8)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_req        <= REQ_NONE;
      r_id         <= '0;
      r_addr       <= '0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_starve_cnt <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_wready <= 1'b0;
      r_ifu_err    <= 1'b0;
      r_lsu_err    <= 1'b0;
      r_ifu_rdata  <= '0;
      r_lsu_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!req.ifu_arvalid || w_grant == REQ_IFU)
            r_starve_cnt <= '0;
          else if (w_grant != REQ_NONE && r_starve_cnt < c_STARVE_MAX)
            r_starve_cnt <= r_starve_cnt + 4'd1;
          if (w_grant != REQ_NONE) begin
            r_req  <= w_grant;
            r_id   <= w_gid;
            r_addr <= w_gaddr;
            r_size <= w_gsize;
            if (w_grant == REQ_LSU_W) begin
              r_wdata   <= req.lsu_wdata;
              r_wstrb   <= req.lsu_wstrb[3:0];
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR_AWW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_AR;
            end
          end
        end
        S_RD_AR: begin
          if (axi.m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (axi.m_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= S_RESP;
            if (r_req == REQ_IFU) begin
              r_ifu_rvalid <= 1'b1;
              r_ifu_err    <= w_rerr;
              r_ifu_rdata  <= w_rd_data;
            end else begin
              r_lsu_rvalid <= 1'b1;
              r_lsu_err    <= w_rerr;
              r_lsu_rdata  <= w_rd_data;
            end
          end
        end
        S_WR_AWW: begin
          // Address and data channels complete independently, in either order.
          if (r_awvalid && axi.m_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && axi.m_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (axi.m_bvalid) begin
            r_bready     <= 1'b0;
            r_lsu_wready <= 1'b1;
            r_lsu_err    <= w_berr;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_ifu_rvalid <= 1'b0;
          r_lsu_rvalid <= 1'b0;
          r_lsu_wready <= 1'b0;
          r_ifu_err    <= 1'b0;
          r_lsu_err    <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign axi.m_arvalid = r_arvalid;
  assign axi.m_araddr  = r_addr;
  assign axi.m_arsize  = r_size;
  assign axi.m_arlen   = c_LEN_SINGLE;
  assign axi.m_arburst = c_BURST_INCR;
  assign axi.m_arid    = r_id;
  assign axi.m_rready  = r_rready;
  assign axi.m_awvalid = r_awvalid;
  assign axi.m_awaddr  = r_addr;
  assign axi.m_awsize  = r_size;
  assign axi.m_awlen   = c_LEN_SINGLE;
  assign axi.m_awburst = c_BURST_INCR;
  assign axi.m_awid    = r_id;
  assign axi.m_wvalid  = r_wvalid;
  assign axi.m_wdata   = w_wdata64;
  assign axi.m_wstrb   = w_wstrb8;
  assign axi.m_wlast   = 1'b1;
  assign axi.m_bready  = r_bready;

  assign req.ifu_rdata  = r_ifu_rdata;
  assign req.ifu_rvalid = r_ifu_rvalid;
  assign req.ifu_err    = r_ifu_err;
  assign req.lsu_rdata  = r_lsu_rdata;
  assign req.lsu_rvalid = r_lsu_rvalid;
  assign req.lsu_wready = r_lsu_wready;
  assign req.lsu_err    = r_lsu_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_mem_arbiter.sv
// ------------------------------------------------------------------
// tb_ysyx_mem_arbiter : directed bench with a reactive single-beat AXI slave
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_ysyx_mem_arbiter;

  logic clk;
  logic rst;

  ysyx_req_if #(.ADDR_W(32), .DATA_W(32)) u_req ();
  ysyx_axi_if #(.ADDR_W(32))              u_axi ();

  ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (u_req),
    .axi (u_axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // slave knobs
  logic [63:0] g_rdata   = 64'h0;
  logic [1:0]  g_rresp   = 2'd0;
  bit          g_bad_rid = 1'b0;
  bit          g_hold_r  = 1'b0;
  int          g_w_delay = 0;

  // monitor results
  logic [3:0]  q_grant[$];
  int          n_ifu_p = 0, n_lr_p = 0, n_lw_p = 0, n_multi = 0;
  logic [2:0]  lsu_ar_size = '0;
  logic [31:0] lsu_ar_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pack_q();
    logic [31:0] v = '0;
    foreach (q_grant[i]) v = (v << 4) | 32'(q_grant[i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reactive slave: ready follows valid one cycle after it appears.
  initial begin : p_slave
    int w_cnt = 0;
    u_axi.m_arready = 0; u_axi.m_rvalid = 0; u_axi.m_rdata = '0; u_axi.m_rresp = '0;
    u_axi.m_rlast = 0; u_axi.m_rid = '0; u_axi.m_awready = 0; u_axi.m_wready = 0;
    u_axi.m_bvalid = 0; u_axi.m_bresp = '0; u_axi.m_bid = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        u_axi.m_arready = 0; u_axi.m_rvalid = 0; u_axi.m_awready = 0;
        u_axi.m_wready = 0; u_axi.m_bvalid = 0; w_cnt = 0;
      end else begin
        u_axi.m_arready = u_axi.m_arvalid;
        u_axi.m_rvalid  = u_axi.m_rready && !g_hold_r;
        u_axi.m_rdata   = g_rdata;
        u_axi.m_rresp   = g_rresp;
        u_axi.m_rlast   = 1'b1;
        u_axi.m_rid     = g_bad_rid ? 4'd3 : u_axi.m_arid;
        u_axi.m_awready = u_axi.m_awvalid;
        if (u_axi.m_wvalid) begin
          u_axi.m_wready = (w_cnt == g_w_delay);
          w_cnt++;
        end else begin
          u_axi.m_wready = 1'b0;
          w_cnt = 0;
        end
        u_axi.m_bvalid = u_axi.m_bready;
        u_axi.m_bresp  = 2'd0;
        u_axi.m_bid    = u_axi.m_awid;
      end
    end
  end

  initial begin : p_mon
    forever begin
      @(negedge clk);
      if (rst) begin
        if (int'(u_req.ifu_rvalid) + int'(u_req.lsu_rvalid) + int'(u_req.lsu_wready) > 1) n_multi++;
        if (u_req.ifu_rvalid) n_ifu_p++;
        if (u_req.lsu_rvalid) n_lr_p++;
        if (u_req.lsu_wready) n_lw_p++;
        if (u_axi.m_arvalid && u_axi.m_arready) begin
          q_grant.push_back(u_axi.m_arid);
          if (u_axi.m_arid == 4'd1) begin
            lsu_ar_size = u_axi.m_arsize;
            lsu_ar_addr = u_axi.m_araddr;
          end
        end
        if (u_axi.m_awvalid && u_axi.m_awready) q_grant.push_back(u_axi.m_awid);
      end
    end
  end

  // Issues one read at the current cycle and waits (bounded) for its pulse.
  task automatic run_read(input bit is_ifu, input logic [31:0] addr, input logic [7:0] strb,
                          output logic [31:0] data, output logic err, output int lat);
    bit done = 0;
    if (is_ifu) begin
      u_req.ifu_araddr = addr; u_req.ifu_arvalid = 1'b1;
    end else begin
      u_req.lsu_araddr = addr; u_req.lsu_rstrb = strb; u_req.lsu_arvalid = 1'b1;
    end
    lat = 0; data = '0; err = 1'b0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (is_ifu ? u_req.ifu_rvalid : u_req.lsu_rvalid) begin
        data = is_ifu ? u_req.ifu_rdata : u_req.lsu_rdata;
        err  = is_ifu ? u_req.ifu_err   : u_req.lsu_err;
        done = 1;
      end
    end
    u_req.ifu_arvalid = 1'b0;
    u_req.lsu_arvalid = 1'b0;
    tick();
  endtask

  initial begin : p_main
    logic [31:0] d;
    logic        e;
    int          lat;
    bit          busy;

    rst = 1'b0;
    u_req.ifu_araddr = '0; u_req.ifu_arvalid = 0; u_req.lsu_araddr = '0; u_req.lsu_arvalid = 0;
    u_req.lsu_rstrb = '0; u_req.lsu_awaddr = '0; u_req.lsu_awvalid = 0; u_req.lsu_wdata = '0;
    u_req.lsu_wstrb = '0; u_req.lsu_wvalid = 0;
    repeat (3) tick();

    // reset state
    chk("rst_valids", {u_axi.m_arvalid, u_axi.m_awvalid, u_axi.m_wvalid, u_axi.m_rready, u_axi.m_bready}, 0);
    chk("rst_pulses", {u_req.ifu_rvalid, u_req.lsu_rvalid, u_req.lsu_wready, u_req.ifu_err, u_req.lsu_err}, 0);
    chk("rst_data", {u_req.ifu_rdata, u_req.lsu_rdata}, 0);
    chk("rst_axi_bus", {u_axi.m_araddr, u_axi.m_wstrb}, 0);
    rst = 1'b1;
    tick();

    // IFU-only read, minimum latency
    g_rdata = 64'h11223344_55667788;
    u_req.ifu_araddr = 32'h8000_0004; u_req.ifu_arvalid = 1'b1;
    tick();
    chk("ifu_arvalid_c1", u_axi.m_arvalid, 1);
    chk("ifu_ar_fields", {u_axi.m_araddr, u_axi.m_arsize, u_axi.m_arid, u_axi.m_arlen, u_axi.m_arburst},
        {32'h8000_0004, 3'd2, 4'd0, 8'd0, 2'b01});
    tick();
    chk("ifu_rready_c2", {u_axi.m_rready, u_axi.m_arvalid, u_req.ifu_rvalid}, 3'b100);
    tick();
    chk("ifu_pulse_c3", {u_req.ifu_rvalid, u_req.ifu_err}, 2'b10);
    chk("ifu_rdata", u_req.ifu_rdata, 32'h1122_3344);
    u_req.ifu_arvalid = 1'b0;
    tick();
    chk("ifu_pulse_once", u_req.ifu_rvalid, 0);

    // three simultaneous requesters
    q_grant.delete(); n_ifu_p = 0; n_lr_p = 0; n_lw_p = 0;
    u_req.ifu_araddr = 32'h8000_0000; u_req.ifu_arvalid = 1'b1;
    u_req.lsu_araddr = 32'h0F00_0002; u_req.lsu_rstrb = 8'h03; u_req.lsu_arvalid = 1'b1;
    u_req.lsu_awaddr = 32'h0000_0010; u_req.lsu_wdata = 32'h1234_5678; u_req.lsu_wstrb = 8'h0F;
    u_req.lsu_awvalid = 1'b1; u_req.lsu_wvalid = 1'b1;
    busy = 1;
    for (int i = 0; i < 60 && busy; i++) begin
      tick();
      if (u_req.ifu_rvalid) u_req.ifu_arvalid = 1'b0;
      if (u_req.lsu_rvalid) u_req.lsu_arvalid = 1'b0;
      if (u_req.lsu_wready) begin u_req.lsu_awvalid = 1'b0; u_req.lsu_wvalid = 1'b0; end
      busy = u_req.ifu_arvalid | u_req.lsu_arvalid | u_req.lsu_awvalid;
    end
    chk("mix_timeout", busy, 0);
    tick();
    chk("mix_order", pack_q(), 32'h210);
    chk("mix_grants", q_grant.size(), 3);
    chk("mix_lsu_ar", {lsu_ar_size, lsu_ar_addr}, {3'd1, 32'h0F00_0002});
    chk("mix_pulses", {n_ifu_p[3:0], n_lr_p[3:0], n_lw_p[3:0]}, 12'h111);

    // store, wready two cycles after awready
    n_lw_p = 0; g_w_delay = 2;
    u_req.lsu_awaddr = 32'hA000_0004; u_req.lsu_wdata = 32'hDEAD_BEEF; u_req.lsu_wstrb = 8'h0F;
    u_req.lsu_awvalid = 1'b1; u_req.lsu_wvalid = 1'b1;
    tick();
    chk("st_valids_c1", {u_axi.m_awvalid, u_axi.m_wvalid}, 2'b11);
    chk("st_aw_fields", {u_axi.m_awaddr, u_axi.m_awsize, u_axi.m_awid}, {32'hA000_0004, 3'd2, 4'd2});
    chk("st_wstrb", u_axi.m_wstrb, 8'hF0);
    chk("st_wdata", u_axi.m_wdata, 64'hDEADBEEF_DEADBEEF);
    chk("st_wlast", u_axi.m_wlast, 1);
    tick();
    chk("st_aw_drop_c2", {u_axi.m_awvalid, u_axi.m_wvalid}, 2'b01);
    tick();
    chk("st_w_wait_c3", {u_axi.m_wvalid, u_axi.m_bready, u_req.lsu_wready}, 3'b100);
    tick();
    chk("st_bready_c4", {u_axi.m_bready, u_axi.m_wvalid, u_req.lsu_wready}, 3'b100);
    tick();
    chk("st_pulse_c5", {u_req.lsu_wready, u_req.lsu_err}, 2'b10);
    u_req.lsu_awvalid = 1'b0; u_req.lsu_wvalid = 1'b0;
    tick();
    chk("st_pulse_once", {u_req.lsu_wready, n_lw_p[3:0]}, 5'h01);
    g_w_delay = 0;

    // starvation guard
    q_grant.delete();
    u_req.ifu_araddr = 32'h8000_0000; u_req.ifu_arvalid = 1'b1;
    u_req.lsu_araddr = 32'h0000_0100; u_req.lsu_rstrb = 8'h0F; u_req.lsu_arvalid = 1'b1;
    busy = 1;
    for (int i = 0; i < 80 && busy; i++) begin
      tick();
      if (u_req.ifu_rvalid) begin
        u_req.ifu_arvalid = 1'b0; u_req.lsu_arvalid = 1'b0; busy = 0;
      end
    end
    chk("starve_timeout", busy, 0);
    tick();
    chk("starve_order", pack_q(), 32'h11110);
    chk("starve_cnt_clr", dut.r_starve_cnt, 0);

    // error responses
    g_rdata = 64'hAAAABBBB_CCCCDDDD; g_rresp = 2'd2;
    run_read(1'b0, 32'h0000_0104, 8'h0F, d, e, lat);
    chk("err_resp", {e, d}, {1'b1, 32'hAAAA_BBBB});
    chk("err_resp_lat", lat, 3);
    g_rresp = 2'd0; g_bad_rid = 1'b1;
    run_read(1'b0, 32'h0000_0200, 8'h01, d, e, lat);
    chk("err_rid", {e, d}, {1'b1, 32'hCCCC_DDDD});
    g_bad_rid = 1'b0;
    run_read(1'b1, 32'h0000_0300, 8'h00, d, e, lat);
    chk("err_recover", {e, d, lat[3:0]}, {1'b0, 32'hCCCC_DDDD, 4'd3});

    // reset while waiting in RD_R
    g_hold_r = 1'b1;
    u_req.ifu_araddr = 32'h8000_0010; u_req.ifu_arvalid = 1'b1;
    tick();
    tick();
    chk("mid_rready", {u_axi.m_rready, u_axi.m_arvalid}, 2'b10);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_axi", {u_axi.m_rready, u_axi.m_arvalid, u_axi.m_awvalid, u_axi.m_wvalid, u_axi.m_bready}, 0);
    chk("async_rst_req", {u_req.ifu_rvalid, u_req.ifu_rdata, u_req.lsu_rdata}, 0);
    u_req.ifu_arvalid = 1'b0; g_hold_r = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    q_grant.delete();
    g_rdata = 64'h01234567_89ABCDEF;
    run_read(1'b1, 32'h8000_0008, 8'h00, d, e, lat);
    chk("post_rst_read", {e, d, lat[3:0]}, {1'b0, 32'h89AB_CDEF, 4'd3});
    chk("post_rst_fresh_ar", {q_grant.size() == 1 ? 4'd1 : 4'd0, q_grant.size() > 0 ? q_grant[0] : 4'hF}, 8'h10);

    chk("no_double_pulse", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
